alu_mul_sequencer: RTL and testbench

Sequential 32x32 -> 64-bit multiplier controller that reuses the EX-stage ALU for shift-add iterations instead of a dedicated multiplier array. It sits beside the EX stage and owns the mux in front of the ALU's `dataA`/`dataB`/`Signal` inputs. The pipeline's own EX operation always wins the ALU. The sequencer consumes an ALU cycle only when EX does not request it, and stalls otherwise.

---
 rtl/alu_mul_sequencer.sv | 161 ++++++++++++++++
 tb/tb_alu_mul_sequencer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/alu_mul_sequencer.sv
// Shift-add 32x32->64 multiplier that borrows the EX-stage ALU whenever EX leaves it idle.
// Optional two's-complement support under `MULSEQ_SIGNED_EN.
module alu_mul_sequencer #(
    parameter int ITER = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        is_signed,
    output logic        ready,
    output logic        done,
    output logic [31:0] product_hi,
    output logic [31:0] product_lo,
    input  logic        ex_req,
    input  logic [31:0] ex_dataA,
    input  logic [31:0] ex_dataB,
    input  logic [2:0]  ex_signal,
    output logic [31:0] alu_dataA,
    output logic [31:0] alu_dataB,
    output logic [2:0]  alu_signal,
    input  logic [31:0] alu_dataOut
);

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [5:0] CNT_LAST = 6'(ITER - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] m_q, m_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        sgn_q, sgn_d;
    logic [31:0] prod_hi_q, prod_hi_d;
    logic [31:0] prod_lo_q, prod_lo_d;

    logic        last_iter;
    logic        seq_sub;
    logic [31:0] seq_b;
    logic        b_eff31;
    logic        carry32;
    logic        s32;
    logic        consume;

`ifndef MULSEQ_SIGNED_EN
    logic unused_is_signed;
    assign unused_is_signed = is_signed;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            m_q       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            cnt_q     <= '0;
            sgn_q     <= 1'b0;
            prod_hi_q <= '0;
            prod_lo_q <= '0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            cnt_q     <= cnt_d;
            sgn_q     <= sgn_d;
            prod_hi_q <= prod_hi_d;
            prod_lo_q <= prod_lo_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        cnt_d     = cnt_q;
        sgn_d     = sgn_q;
        prod_hi_d = prod_hi_q;
        prod_lo_d = prod_lo_q;

        last_iter = (cnt_q == CNT_LAST);
        seq_b     = lo_q[0] ? m_q : 32'd0;
        seq_sub   = 1'b0;
`ifdef MULSEQ_SIGNED_EN
        // Multiplier sign bit carries weight -2^31, so its partial product is subtracted.
        seq_sub   = sgn_q && last_iter && lo_q[0];
`endif
        // Bit 31 of the operand the ALU actually adds (inverted for hi + ~M + 1).
        b_eff31   = seq_sub ? ~seq_b[31] : seq_b[31];
        carry32   = (hi_q[31] & b_eff31) | ((hi_q[31] | b_eff31) & ~alu_dataOut[31]);
        s32       = carry32;
`ifdef MULSEQ_SIGNED_EN
        if (sgn_q) begin
            s32 = hi_q[31] ^ b_eff31 ^ carry32;
        end
`endif

        consume = (state_q == S_RUN) && !ex_req;

        if (consume) begin
            alu_dataA  = hi_q;
            alu_dataB  = seq_b;
            alu_signal = seq_sub ? ALU_SUB : ALU_ADD;
        end else begin
            alu_dataA  = ex_dataA;
            alu_dataB  = ex_dataB;
            alu_signal = ex_signal;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    m_d     = op_a;
                    lo_d    = op_b;
                    hi_d    = '0;
                    cnt_d   = '0;
`ifdef MULSEQ_SIGNED_EN
                    sgn_d   = is_signed;
`else
                    sgn_d   = 1'b0;
`endif
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (consume) begin
                    hi_d  = {s32, alu_dataOut[31:1]};
                    lo_d  = {alu_dataOut[0], lo_q[31:1]};
                    cnt_d = cnt_q + 6'd1;
                    if (last_iter) begin
                        // Capture on entry to DONE so the product is valid alongside done.
                        prod_hi_d = {s32, alu_dataOut[31:1]};
                        prod_lo_d = {alu_dataOut[0], lo_q[31:1]};
                        state_d   = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign ready      = (state_q == S_IDLE);
    assign done       = (state_q == S_DONE);
    assign product_hi = prod_hi_q;
    assign product_lo = prod_lo_q;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed bench for alu_mul_sequencer with a behavioural ALU and hand-computed products.
module tb_alu_mul_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        is_signed;
    logic        ready;
    logic        done;
    logic [31:0] product_hi;
    logic [31:0] product_lo;
    logic        ex_req;
    logic [31:0] ex_dataA;
    logic [31:0] ex_dataB;
    logic [2:0]  ex_signal;
    logic [31:0] alu_dataA;
    logic [31:0] alu_dataB;
    logic [2:0]  alu_signal;
    logic [31:0] alu_dataOut;

    int checks = 0;
    int fails  = 0;

    alu_mul_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
        .is_signed(is_signed), .ready(ready), .done(done),
        .product_hi(product_hi), .product_lo(product_lo),
        .ex_req(ex_req), .ex_dataA(ex_dataA), .ex_dataB(ex_dataB), .ex_signal(ex_signal),
        .alu_dataA(alu_dataA), .alu_dataB(alu_dataB), .alu_signal(alu_signal),
        .alu_dataOut(alu_dataOut)
    );

    // Behavioural ALU: SUB subtracts, every other code adds.
    assign alu_dataOut = (alu_signal == 3'b110) ? (alu_dataA - alu_dataB) : (alu_dataA + alu_dataB);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // One multiply: optional EX stall window and optional busy-time start pulse.
    task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic sgn, input int stall_at, input int stall_len,
                           input int busy_at, input logic [31:0] exp_hi,
                           input logic [31:0] exp_lo, input int exp_lat,
                           input logic exp_sub);
        int cyc;
        int extra;
        logic seen;
        logic sub_seen;
        seen = 1'b0;
        sub_seen = 1'b0;
        cyc = 0;
        extra = 0;
        chk({tag, "_ready_pre"}, 64'(ready), 64'd1);
        op_a = a;
        op_b = b;
        is_signed = sgn;
        start = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            start = 1'b0;
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (cyc == busy_at) begin
                start = 1'b1;
                op_a = 32'hDEAD_BEEF;
                op_b = 32'h1234_5678;
            end
            ex_req = (cyc >= stall_at) && (cyc < stall_at + stall_len);
            ex_dataA = $urandom;
            ex_dataB = $urandom;
            ex_signal = 3'($urandom_range(0, 7));
            #1;
            if (ex_req) begin
                chk({tag, "_stall_A"}, 64'(alu_dataA), 64'(ex_dataA));
                chk({tag, "_stall_B"}, 64'(alu_dataB), 64'(ex_dataB));
                chk({tag, "_stall_sig"}, 64'(alu_signal), 64'(ex_signal));
            end else if (alu_signal == 3'b110) begin
                sub_seen = 1'b1;
            end
        end
        ex_req = 1'b0;
        start = 1'b0;
        chk({tag, "_done_seen"}, 64'(seen), 64'd1);
        chk({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
        chk({tag, "_ready_in_done"}, 64'(ready), 64'd0);
        chk({tag, "_product"}, {product_hi, product_lo}, {exp_hi, exp_lo});
        chk({tag, "_sub_seen"}, 64'(sub_seen), 64'(exp_sub));
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done) extra++;
        end
        chk({tag, "_extra_done"}, 64'(extra), 64'd0);
        chk({tag, "_ready_post"}, 64'(ready), 64'd1);
        chk({tag, "_product_hold"}, {product_hi, product_lo}, {exp_hi, exp_lo});
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        op_a = '0;
        op_b = '0;
        is_signed = 1'b0;
        ex_req = 1'b0;
        ex_dataA = 32'hA5A5_0001;
        ex_dataB = 32'h0F0F_0002;
        ex_signal = 3'b011;
        #22;
        chk("rst_ready", 64'(ready), 64'd1);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_product", {product_hi, product_lo}, 64'd0);
        chk("rst_passA", 64'(alu_dataA), 64'h A5A5_0001);
        chk("rst_passSig", 64'(alu_signal), 64'd3);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_mul("mul7x6", 32'd7, 32'd6, 1'b0, 1000, 0, 0,
                32'h0, 32'h2A, 33, 1'b0);
        run_mul("mulFFxFF", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1000, 0, 0,
                32'hFFFF_FFFE, 32'h0000_0001, 33, 1'b0);
        run_mul("stall", 32'h1234, 32'h10, 1'b0, 10, 5, 0,
                32'h0, 32'h0001_2340, 38, 1'b0);
        run_mul("busy_start", 32'd3, 32'd9, 1'b0, 1000, 0, 5,
                32'h0, 32'd27, 33, 1'b0);

        // Reset part-way through a multiply.
        op_a = 32'd11;
        op_b = 32'd13;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", 64'(ready), 64'd1);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_product", {product_hi, product_lo}, 64'd0);
        chk("midrst_passA", 64'(alu_dataA), 64'(ex_dataA));
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_no_done", 64'(done), 64'd0);
        run_mul("after_rst", 32'd7, 32'd6, 1'b0, 1000, 0, 0,
                32'h0, 32'h2A, 33, 1'b0);

`ifdef MULSEQ_SIGNED_EN
        run_mul("sgn_neg_x5", 32'hFFFF_FFFD, 32'd5, 1'b1, 1000, 0, 0,
                32'hFFFF_FFFF, 32'hFFFF_FFF1, 33, 1'b0);
        run_mul("sgn_5xneg", 32'd5, 32'hFFFF_FFFD, 1'b1, 1000, 0, 0,
                32'hFFFF_FFFF, 32'hFFFF_FFF1, 33, 1'b1);
`else
        run_mul("sgn_neg_x5", 32'hFFFF_FFFD, 32'd5, 1'b1, 1000, 0, 0,
                32'h0000_0004, 32'hFFFF_FFF1, 33, 1'b0);
        run_mul("sgn_5xneg", 32'd5, 32'hFFFF_FFFD, 1'b1, 1000, 0, 0,
                32'h0000_0004, 32'hFFFF_FFF1, 33, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
